// File: rtl/score_bcd_conv_if.sv
// Bundle between the game score source and the BCD converter feeding the 7-segment driver.
// Handshake: no backpressure. done is a one-cycle strobe on the cycle digits/sat update; busy is
// high while a conversion is in flight; digits/sat hold their value between done strobes.
interface score_bcd_conv_if;
  logic [15:0] in_score;
  logic [15:0] digits;
  logic        busy;
  logic        done;
  logic        sat;

  modport master (
    output in_score,
    input  digits,
    input  busy,
    input  done,
    input  sat
  );

  modport slave (
    input  in_score,
    output digits,
    output busy,
    output done,
    output sat
  );
endinterface

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter: reconverts whenever the score changes,
// clamps to SAT_VALUE and holds four packed BCD digits stable between conversions.
module score_bcd_conv #(
  parameter int SAT_VALUE = 9999
) (
  input  logic                   clk,
  input  logic                   clr,
  score_bcd_conv_if.slave        bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] SAT_V = 16'(SAT_VALUE);

  state_t      state_q, state_d;
  logic [15:0] held_q, held_d;
  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sat_pend_q, sat_pend_d;
  logic [15:0] digits_q, digits_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sat_disp_q, sat_disp_d;
  logic [15:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sat_pend_d = sat_pend_q;
    digits_d   = digits_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sat_disp_d = sat_disp_q;

    unique case (state_q)
      ST_IDLE: begin
        // Raw input is compared so that any change, even between two clamped values, reconverts.
        if (bus.in_score != held_q) begin
          held_d     = bus.in_score;
          bin_d      = (bus.in_score > SAT_V) ? SAT_V : bus.in_score;
          sat_pend_d = (bus.in_score > SAT_V);
          bcd_d      = 16'h0000;
          cnt_d      = 5'd0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Top bit of the adjusted accumulator is always 0 for clamped inputs and is dropped.
        bcd_d = {bcd_adj[14:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        digits_d   = bcd_q;
        sat_disp_d = sat_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      held_q     <= 16'h0000;
      bin_q      <= 16'h0000;
      bcd_q      <= 16'h0000;
      cnt_q      <= 5'd0;
      sat_pend_q <= 1'b0;
      digits_q   <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_disp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sat_pend_q <= sat_pend_d;
      digits_q   <= digits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_disp_q <= sat_disp_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sat    = sat_disp_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// Directed bench for score_bcd_conv: expected {sat, digits} pushed at stimulus time, popped on done.
module tb_score_bcd_conv;

  logic       clk;
  logic       clr;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;
  logic [16:0] exp_q[$];

  score_bcd_conv_if bus ();

  score_bcd_conv #(.SAT_VALUE(9999)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {15'd0, bus.sat, bus.digits}, 32'h1ffff);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("scoreboard", {15'd0, bus.sat, bus.digits}, {15'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name, input logic [15:0] exp_digits);
    check(name, {13'd0, bus.busy, bus.done, bus.sat, bus.digits}, {16'd0, exp_digits});
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done !== 1'b1 && n < 60);
    if (bus.done !== 1'b1) begin
      check({name, "_timeout"}, 32'(n), 32'(exp_lat));
    end else begin
      check({name, "_latency"}, 32'(n), 32'(exp_lat));
    end
  endtask

  task automatic convert(input logic [15:0] val, input logic [16:0] exp);
    exp_q.push_back(exp);
    bus.in_score = val;
    wait_done("conv", 18);
  endtask

  logic [15:0] vin  [11] = '{16'd7, 16'd1000, 16'd9999, 16'd1, 16'd10, 16'd99,
                             16'd100, 16'd999, 16'd4321, 16'd5678, 16'd8090};
  logic [15:0] vexp [11] = '{16'h0007, 16'h1000, 16'h9999, 16'h0001, 16'h0010, 16'h0099,
                             16'h0100, 16'h0999, 16'h4321, 16'h5678, 16'h8090};

  initial begin
    n_vec = 0;
    n_err = 0;
    clr = 1'b1;
    bus.in_score = 16'd0;

    // reset with zero input, then no conversion should start
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("reset_zero", 16'h0000);
    end
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("zero_no_busy", {31'd0, bus.busy}, 32'd0);
    end

    // reset held with 1234 on the input
    clr = 1'b1;
    bus.in_score = 16'd1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("reset_1234", 16'h0000);
    end
    clr = 1'b0;
    exp_q.push_back({1'b0, 16'h1234});
    tick();
    check("busy_rise", {31'd0, bus.busy}, 32'd1);
    wait_done("first_conv", 17);
    tick();
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);

    // directed values
    for (int i = 0; i < 11; i++) begin
      convert(vin[i], {1'b0, vexp[i]});
    end

    // saturation
    convert(16'd10000, {1'b1, 16'h9999});
    convert(16'd65535, {1'b1, 16'h9999});
    convert(16'd42, {1'b0, 16'h0042});

    // change mid-conversion
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h0042});
    bus.in_score = 16'd5;
    for (int i = 0; i < 8; i++) tick();
    bus.in_score = 16'd42;
    wait_done("mid_first", 10);
    check("mid_busy_low", {31'd0, bus.busy}, 32'd0);
    tick();
    check("mid_busy_back", {31'd0, bus.busy}, 32'd1);
    wait_done("mid_second", 17);

    // reset mid-conversion
    tick();
    bus.in_score = 16'd321;
    for (int i = 0; i < 7; i++) tick();
    check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    clr = 1'b1;
    tick();
    check_idle_outputs("abort", 16'h0000);
    clr = 1'b0;
    exp_q.push_back({1'b0, 16'h0321});
    wait_done("restart", 18);

    // no-change hold
    for (int i = 0; i < 100; i++) begin
      tick();
      check_idle_outputs("hold", 16'h0321);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_bcd_conv.md
# score_bcd_conv

Sequential binary-to-BCD converter between the game `fsm` (`out_score`) and the 7-segment driver `ssled`. It watches the 16-bit binary score and, whenever it changes, runs a 16-step shift-and-add-3 (double-dabble) conversion. It then presents four packed BCD digits, held stable between conversions, so the display path never needs a combinational divider. Scores above 9999 saturate to 9999 and raise a flag.

## Interface

Parameters:
- `SAT_VALUE`, 9999: clamp threshold. Binary inputs greater than this convert as this value.

Ports:
- `clk`, in, 1: system clock, 50 MHz master clock.
- `clr`, in, 1: reset, synchronous, active-high.
- `in_score`, in, 16: binary score from `fsm`, unsigned. It may change on any cycle.
- `digits`, out, 16: packed BCD, thousands in [15:12] down to units in [3:0]. Registered.
- `busy`, out, 1: high while a conversion is in progress.
- `done`, out, 1: one-cycle pulse on the cycle `digits` is updated.
- `sat`, out, 1: high when the currently displayed value was clamped. Registered alongside `digits`.

## Operation

- Reset values of all outputs are 0: `digits`=16'h0000, `busy`=0, `done`=0, `sat`=0. Reset also clears `held`=0, state=IDLE and `cnt`=0.
- Internal state:
  - `held[15:0]`: last captured input.
  - `bin[15:0]`: shift source.
  - `bcd[15:0]`: accumulator.
  - `cnt[4:0]`: iteration count.
  - `sat_q`: pending saturation flag.
- **IDLE**
  - Compare `in_score` with `held`. If they are equal, stay in IDLE.
  - If they differ:
    - `held`<=`in_score`.
    - `bin`<=min(`in_score`, `SAT_VALUE`).
    - `sat_q`<=(`in_score`>`SAT_VALUE`).
    - `bcd`<=0, `cnt`<=0, `busy`<=1.
    - Go to SHIFT.
- **SHIFT**, one iteration per cycle:
  - Adjust each `bcd` nibble: if the nibble is ≥5, add 3. Adjustments are computed combinationally from the current `bcd`.
  - Shift {adjusted_bcd, `bin`} left by 1.
  - `cnt`<=`cnt`+1.
  - After the iteration where `cnt`==15, go to DONE.
- **DONE**
  - `digits`<=`bcd`, `sat`<=`sat_q`, `done`<=1, `busy`<=0.
  - Go to IDLE.
- Arithmetic and width rules:
  - The 16-bit BCD accumulator suffices because the input is clamped to ≤9999. Bits shifted out of `bcd[15]` are always 0 and are discarded.
  - The comparison uses the raw `in_score`, not the clamped value. A change between two values that are both >9999 therefore triggers a reconversion. The result is identical, but `done` still pulses.
- Boundary conditions:
  - **Input change during SHIFT/DONE:** ignored for the current conversion. In IDLE, the new value differs from `held`, so a new conversion starts on the first IDLE cycle. No update is lost; only the latest value is converted.
  - **Input returns to `held` before IDLE:** no reconversion. The displayed value is correct.
  - **`clr` mid-conversion:** abort. All registers return to their reset values on that edge, and `digits` reads 0 regardless of `in_score`. If `in_score`≠0 after reset, conversion restarts from IDLE.
  - **`in_score`=0 after reset:** no conversion and no `done` pulse, because `held` is already 0.
  - **`clr` has priority** over every other transition.

## Timing

- Input capture happens at edge E0 (state IDLE, `in_score`≠`held`).
- SHIFT iterations occur at edges E1..E16.
- DONE executes at edge E17: `digits`, `sat` and `done` become visible after E17.
- Latency from capture to valid output: 17 clock edges. Added to the cycle that detects the change, the total is 18 cycles.
- `busy` is high from after E0 until after E17, i.e. 17 cycles.
- `done` is high for exactly one cycle, after E17.
- Back-to-back: the earliest next capture is edge E18. Minimum conversion period is 18 cycles (0.36 µs at 50 MHz), far faster than score updates at the render clock rate.
- `digits` and `sat` change only at DONE edges or on `clr`; they are glitch-free for the `ssled` segment clock domain.

## Test plan

- **Reset:** hold `clr` 3 cycles with `in_score`=1234 → `digits`=0x0000, `busy`=0, `done`=0, `sat`=0 throughout. Release → `busy` rises next cycle, and `digits`=0x1234 after 18 cycles with a single `done` pulse.
- **Exhaustive correctness:** sweep `in_score` 0..9999, waiting for `done` each time (skipping 0 after reset) → `digits` equals the BCD of the input and `sat`=0. Examples: 7→0x0007, 1000→0x1000, 9999→0x9999.
- **Saturation:** `in_score`=10000 → `digits`=0x9999, `sat`=1. Then 65535 → `done` pulses again, `digits`=0x9999, `sat`=1. Then 42 → 0x0042, `sat`=0.
- **Change mid-conversion:** set 5, then 8 cycles later set 42 → first `done` with 0x0005, then exactly one more `done` 18 cycles later with 0x0042. `busy` drops for exactly 1 cycle between the two conversions.
- **Reset mid-conversion:** set 321, assert `clr` for 1 cycle at cycle 6 of SHIFT → `busy`=0 and `digits`=0 after that edge, with no `done`. Conversion restarts and yields 0x0321 with `done` 18 cycles after `clr` deasserts.
- **No-change hold:** keep `in_score` constant for 100 cycles after a conversion → `busy` stays 0, no `done` pulses, and `digits` stays stable.
